// File: rtl/conv_accum_pkg.sv
// Shared types and default widths for the convolution accumulator.
package conv_accum_pkg;

    // Accumulator controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_IN_WIDTH  = 16;
    localparam int DEF_ACC_WIDTH = 24;
    localparam int DEF_CNT_WIDTH = 6;

endpackage

// File: rtl/conv_accum_reg_adder_reg.sv
// Registered adder: A + B captured on en_in, cleared synchronously by clr_in.
// carry_o is the registered carry of the most recent enabled addition.
module adder_reg #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en_in,
    input  logic             clr_in,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    output logic [WIDTH-1:0] A_add_B_o,
    output logic             carry_o
);

    logic [WIDTH-1:0] sum_d;
    logic             carry_d;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;

    // Full-width add; the extra bit becomes the carry out.
    always_comb begin
        {carry_d, sum_d} = {1'b0, A_in} + {1'b0, B_in};
    end

    // Clear takes priority over enable so a restart never mixes in a term.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else if (clr_in) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else if (en_in) begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign A_add_B_o = sum_q;
    assign carry_o   = carry_q;

endmodule

// File: rtl/conv_accum_reg.sv
// Sequential accumulator: sums len_i unsigned terms received over a
// valid/ready handshake and presents the sum on a second handshake.
module conv_accum_reg
    import conv_accum_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start_i,
    input  logic [CNT_WIDTH-1:0] len_i,
    input  logic                 term_valid_i,
    input  logic [IN_WIDTH-1:0]  term_i,
    output logic                 term_ready_o,
    output logic                 sum_valid_o,
    output logic [ACC_WIDTH-1:0] sum_o,
    input  logic                 sum_ready_i,
    output logic                 busy_o,
    output logic                 ovf_o
);

    state_t               state_q;
    logic [CNT_WIDTH-1:0] len_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 ovf_q;

    logic                 acc_en;
    logic                 acc_clr;
    logic                 acc_carry;
    logic [ACC_WIDTH-1:0] term_ext;

    assign acc_en   = (state_q == ST_ACC) && term_valid_i;
    assign acc_clr  = (state_q == ST_IDLE) && start_i;
    assign term_ext = ACC_WIDTH'(term_i);

    // The accumulator feeds back on itself: A is its own registered sum.
    adder_reg #(
        .WIDTH(ACC_WIDTH)
    ) u_acc (
        .clk      (clk),
        .rstn     (rstn),
        .en_in    (acc_en),
        .clr_in   (acc_clr),
        .A_in     (sum_o),
        .B_in     (term_ext),
        .A_add_B_o(sum_o),
        .carry_o  (acc_carry)
    );

    // Controller: length latch, term counter and sticky overflow.
    // ovf_q folds in the carry of every earlier accepted term; the carry of
    // the latest term is still held in the adder and ORed in at the output.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        len_q   <= len_i;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                        state_q <= (len_i == '0) ? ST_DONE : ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (term_valid_i) begin
                        ovf_q <= ovf_q | acc_carry;
                        cnt_q <= cnt_q + CNT_WIDTH'(1);
                        if (cnt_q == len_q - CNT_WIDTH'(1)) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (sum_ready_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode only from registers; no input reaches an output directly.
    assign term_ready_o = (state_q == ST_ACC);
    assign sum_valid_o  = (state_q == ST_DONE);
    assign busy_o       = (state_q != ST_IDLE);
    assign ovf_o        = ovf_q | acc_carry;

endmodule

// File: tb/tb_conv_accum_reg.sv
// Directed bench for conv_accum_reg with hand-computed sums (16-bit accumulator).
module tb_conv_accum_reg;

    localparam int IW = 16;
    localparam int AW = 16;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start_i;
    logic [CW-1:0] len_i;
    logic          term_valid_i;
    logic [IW-1:0] term_i;
    logic          term_ready_o;
    logic          sum_valid_o;
    logic [AW-1:0] sum_o;
    logic          sum_ready_i;
    logic          busy_o;
    logic          ovf_o;

    int n_checks = 0;
    int n_pass   = 0;

    conv_accum_reg #(
        .IN_WIDTH (IW),
        .ACC_WIDTH(AW),
        .CNT_WIDTH(CW)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start_i     (start_i),
        .len_i       (len_i),
        .term_valid_i(term_valid_i),
        .term_i      (term_i),
        .term_ready_o(term_ready_o),
        .sum_valid_o (sum_valid_o),
        .sum_o       (sum_o),
        .sum_ready_i (sum_ready_i),
        .busy_o      (busy_o),
        .ovf_o       (ovf_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".busy"},  32'(busy_o),       0);
        chk({tag, ".valid"}, 32'(sum_valid_o),  0);
        chk({tag, ".ready"}, 32'(term_ready_o), 0);
    endtask

    task automatic start_run(input int len);
        start_i = 1'b1;
        len_i   = CW'(len);
        step();
        start_i = 1'b0;
        len_i   = '0;
        chk("start.busy", 32'(busy_o), 1);
    endtask

    task automatic feed(input int t);
        term_valid_i = 1'b1;
        term_i       = IW'(t);
        step();
        term_valid_i = 1'b0;
        term_i       = '0;
    endtask

    task automatic finish_run(input string tag, input int exp_sum, input int exp_ovf);
        chk({tag, ".valid"}, 32'(sum_valid_o),  1);
        chk({tag, ".ready"}, 32'(term_ready_o), 0);
        chk({tag, ".sum"},   32'(sum_o),        32'(exp_sum));
        chk({tag, ".ovf"},   32'(ovf_o),        32'(exp_ovf));
        $display("run %s: sum=%0h ovf=%0b", tag, sum_o, ovf_o);
        sum_ready_i = 1'b1;
        step();
        sum_ready_i = 1'b0;
        chk_idle({tag, ".after"});
    endtask

    initial begin
        rstn = 1'b0;
        start_i = 1'b0; len_i = '0; term_valid_i = 1'b0; term_i = '0; sum_ready_i = 1'b0;

        // Reset held with random inputs: every output must read 0.
        for (int i = 0; i < 4; i++) begin
            start_i      = 1'($urandom);
            len_i        = CW'($urandom);
            term_valid_i = 1'($urandom);
            term_i       = IW'($urandom);
            sum_ready_i  = 1'($urandom);
            #2;
            chk_idle("rst");
            chk("rst.sum", 32'(sum_o), 0);
            chk("rst.ovf", 32'(ovf_o), 0);
            step();
        end
        start_i = 1'b0; len_i = '0; term_valid_i = 1'b0; term_i = '0; sum_ready_i = 1'b0;
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_idle("post_rst");
            chk("post_rst.sum", 32'(sum_o), 0);
        end
        $display("run reset: outputs idle");

        // Basic: 1+2+3+4 back to back.
        start_run(4);
        chk("basic.ready0", 32'(term_ready_o), 1);
        chk("basic.valid0", 32'(sum_valid_o), 0);
        feed(1); feed(2); feed(3);
        chk("basic.partial", 32'(sum_o), 6);
        chk("basic.ready3", 32'(term_ready_o), 1);
        feed(4);
        finish_run("basic", 10, 0);

        // Gaps: 100, 200, 300 with two idle cycles between terms.
        start_run(3);
        feed(100);
        chk("gap.sum1", 32'(sum_o), 100);
        step(); step();
        chk("gap.hold", 32'(sum_o), 100);
        chk("gap.ready", 32'(term_ready_o), 1);
        feed(200);
        step(); step();
        chk("gap.sum2", 32'(sum_o), 300);
        feed(300);
        chk("gap.valid", 32'(sum_valid_o), 1);
        chk("gap.sum", 32'(sum_o), 600);

        // Backpressure: DONE held, stray starts and terms ignored.
        start_i = 1'b1; len_i = 6'd5; term_valid_i = 1'b1; term_i = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp.valid", 32'(sum_valid_o), 1);
            chk("bp.sum", 32'(sum_o), 600);
            chk("bp.ready", 32'(term_ready_o), 0);
        end
        start_i = 1'b0; len_i = '0; term_valid_i = 1'b0; term_i = '0;
        finish_run("gaps_bp", 600, 0);
        step();
        chk_idle("bp.noqueue");

        // Overflow: 0xFFFF + 0x0002 wraps to 0x0001.
        start_run(2);
        feed(16'hFFFF);
        chk("ovf.sum1", 32'(sum_o), 32'hFFFF);
        chk("ovf.flag1", 32'(ovf_o), 0);
        feed(16'h0002);
        finish_run("ovf", 1, 1);

        // Zero length: straight to DONE with sum 0, no term consumed.
        term_valid_i = 1'b1; term_i = 16'h0077;
        start_run(0);
        chk("zero.ready", 32'(term_ready_o), 0);
        step();
        chk("zero.hold", 32'(sum_o), 0);
        term_valid_i = 1'b0; term_i = '0;
        finish_run("zero", 0, 0);

        // Single term right after the previous handshake; overflow stays clear.
        start_run(1);
        chk("one.clr", 32'(sum_o), 0);
        feed(5);
        finish_run("one", 5, 0);

        // Mid-run reset discards the partial sum immediately.
        start_run(8);
        feed(10); feed(20); feed(30);
        chk("mid.partial", 32'(sum_o), 60);
        rstn = 1'b0;
        #1;
        chk_idle("mid.rst");
        chk("mid.rst.sum", 32'(sum_o), 0);
        chk("mid.rst.ovf", 32'(ovf_o), 0);
        step(); step();
        rstn = 1'b1;
        step();
        chk_idle("mid.idle");
        start_run(2);
        feed(7); feed(8);
        finish_run("after_rst", 15, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
